// File: rtl/window_seq_ctrl.sv
// Raster sequencer for one 3x3 window bank: issues one read per window and replays
// each read as a result-memory write after a fixed latency. Optional stall counter: WSC_STALL_CNT_EN.
module window_seq_ctrl #(
    parameter int COLS  = 256,
    parameter int ROWS  = 32,
    parameter int RD2WR = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      hold,
    output logic                      rd,
    output logic                      wr,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic [$clog2(COLS)-1:0]   col,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               stall_cnt
);

    localparam int RW  = $clog2(ROWS);
    localparam int CW  = $clog2(COLS);
    localparam int WCW = $clog2(ROWS * COLS + 1);

    localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0]  LAST_COL = CW'(COLS - 1);
    localparam logic [WCW-1:0] LAST_WR  = WCW'(ROWS * COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    // Coordinates of the next window to issue; row_q/col_q hold the last issued one.
    logic [RW-1:0]    nrow_q, nrow_d;
    logic [CW-1:0]    ncol_q, ncol_d;
    logic [WCW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [RD2WR-1:0] dl_q, dl_d;

    // Read-to-write delay line; it keeps shifting through hold because the
    // memory returns zeros on idle cycles and the rd-low slots never write.
    generate
        for (genvar gi = 0; gi < RD2WR; gi++) begin : g_dl
            if (gi == 0) begin : g_head
                assign dl_d[gi] = rd_q;
            end else begin : g_tap
                assign dl_d[gi] = dl_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        rd_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        row_d    = row_q;
        col_d    = col_q;
        nrow_d   = nrow_q;
        ncol_d   = ncol_q;
        wr_cnt_d = wr_cnt_q;

        if (state_q != IDLE && dl_q[RD2WR-1]) begin
            wr_cnt_d = wr_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    row_d    = '0;
                    col_d    = '0;
                    nrow_d   = '0;
                    ncol_d   = '0;
                    wr_cnt_d = '0;
                end
            end
            RUN: begin
                rd_d = !hold;
                if (!hold) begin
                    row_d = nrow_q;
                    col_d = ncol_q;
                    if (ncol_q == LAST_COL) begin
                        ncol_d = '0;
                        if (nrow_q == LAST_ROW) begin
                            state_d = DRAIN;
                        end else begin
                            nrow_d = nrow_q + 1'b1;
                        end
                    end else begin
                        ncol_d = ncol_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dl_q[RD2WR-1] && wr_cnt_q == LAST_WR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            nrow_q   <= '0;
            ncol_q   <= '0;
            wr_cnt_q <= '0;
            dl_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            row_q    <= row_d;
            col_q    <= col_d;
            nrow_q   <= nrow_d;
            ncol_q   <= ncol_d;
            wr_cnt_q <= wr_cnt_d;
            dl_q     <= dl_d;
        end
    end

    assign rd   = rd_q;
    assign wr   = dl_q[RD2WR-1];
    assign row  = row_q;
    assign col  = col_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef WSC_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && start) begin
            stall_cnt_d = '0;
        end else if (state_q == RUN && hold && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Self-checking bench for window_seq_ctrl: a scoreboard tracks raster order of reads and
// the read-to-write latency; scenario tasks check frame-level timing.
`timescale 1ns/1ps
module tb_window_seq_ctrl;

    localparam int COLS  = 256;
    localparam int ROWS  = 32;
    localparam int RD2WR = 3;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int NWIN  = ROWS * COLS;
`ifdef WSC_STALL_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          hold;
    logic          rd;
    logic          wr;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    window_seq_ctrl #(.COLS(COLS), .ROWS(ROWS), .RD2WR(RD2WR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hold      (hold),
        .rd        (rd),
        .wr        (wr),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .done      (done),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each read pushes its edge number; each write must pop one RD2WR edges later.
    int rd_q[$];
    int exp_row = 0;
    int exp_col = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_q.delete();
            exp_row = 0;
            exp_col = 0;
        end else begin
            if (!busy) begin
                exp_row = 0;
                exp_col = 0;
            end
            if (rd) begin
                total++;
                if (row !== RW'(exp_row) || col !== CW'(exp_col)) begin
                    bad++;
                    $display("FAIL raster: got (%0d,%0d) want (%0d,%0d) cyc=%0d", row, col, exp_row, exp_col, cyc);
                end
                rd_q.push_back(cyc);
                exp_col++;
                if (exp_col == COLS) begin
                    exp_col = 0;
                    exp_row++;
                end
            end
            if (wr) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_orphan: wr=1 with no pending rd, want wr=0 cyc=%0d", cyc);
                end else begin
                    int t;
                    t = rd_q.pop_front();
                    if (cyc !== t + RD2WR) begin
                        bad++;
                        $display("FAIL wr_latency: got %0d want %0d cycles", cyc - t, RD2WR);
                    end
                end
            end
        end
    end

    // Frame statistics, indexed by edge number k relative to the start edge E0.
    int st_rd, st_wr, st_rd_first, st_rd_last, st_wr_first, st_wr_last;
    int st_rd_runs, st_wr_runs, st_done_n, st_done_e, st_busy_fall_e;
    int st_busy_after_done, st_rd_after_done, st_wr_in_rst, st_frozen_bad;
    int st_coord_256, st_coord_257, st_last_coord;

    task automatic run_frame(input int budget, input int hold_at, input int hold_len,
                             input int start2_at, input int rst_at, input int rst_len);
        bit prev_rd = 0, prev_wr = 0, prev_busy = 0;
        logic [CW-1:0] frozen_col = '0;
        st_rd = 0; st_wr = 0; st_rd_first = -1; st_rd_last = -1; st_wr_first = -1;
        st_wr_last = -1; st_rd_runs = 0; st_wr_runs = 0; st_done_n = 0; st_done_e = -1;
        st_busy_fall_e = -1; st_busy_after_done = 0; st_rd_after_done = 0;
        st_wr_in_rst = 0; st_frozen_bad = 0; st_coord_256 = -1; st_coord_257 = -1;
        st_last_coord = -1;
        start = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k >= rst_at && k < rst_at + rst_len && wr) st_wr_in_rst++;
            if (rd) begin
                st_rd++;
                if (st_rd_first < 0) st_rd_first = k;
                if (!prev_rd) st_rd_runs++;
                st_rd_last = k;
                st_last_coord = {row, col};
                if (k == 256) st_coord_256 = {row, col};
                if (k == 257) st_coord_257 = {row, col};
            end
            if (wr) begin
                st_wr++;
                if (st_wr_first < 0) st_wr_first = k;
                if (!prev_wr) st_wr_runs++;
                st_wr_last = k;
            end
            if (st_done_e >= 0 && k > st_done_e) begin
                if (busy) st_busy_after_done++;
                if (rd) st_rd_after_done++;
            end
            if (done) begin
                st_done_n++;
                st_done_e = k;
            end
            if (prev_busy && !busy && st_busy_fall_e < 0) st_busy_fall_e = k;
            if (k == hold_at - 1) frozen_col = col;
            if (hold_len > 0 && k >= hold_at && k < hold_at + hold_len && col !== frozen_col)
                st_frozen_bad++;
            prev_rd = rd; prev_wr = wr; prev_busy = busy;
            start = (k + 1 == start2_at);
            hold  = (k + 1 >= hold_at && k + 1 < hold_at + hold_len);
            rst_n = !(k + 1 >= rst_at && k + 1 < rst_at + rst_len);
            if (st_done_e >= 0 && k >= st_done_e + 4) break;
        end
        start = 1'b0;
        hold  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        int stray = 0;
        rst_n = 1'b0; start = 1'b1; hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rd !== 1'b0)    begin bad++; $display("FAIL reset_rd: got %b want 0", rd); end
        total++; if (wr !== 1'b0)    begin bad++; $display("FAIL reset_wr: got %b want 0", wr); end
        total++; if (row !== '0)     begin bad++; $display("FAIL reset_row: got %0d want 0", row); end
        total++; if (col !== '0)     begin bad++; $display("FAIL reset_col: got %0d want 0", col); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        total++; if (dut.state_q !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", dut.state_q); end
        rst_n = 1'b1; start = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (rd || busy || wr) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL reset_idle: got %0d active cycles want 0", stray); end
        $display("test_reset: done");
    endtask

    task automatic test_nominal;
        run_frame(NWIN + 100, -10, 0, -1, -1, 0);
        total++; if (st_rd !== NWIN)      begin bad++; $display("FAIL nom_rd_count: got %0d want %0d", st_rd, NWIN); end
        total++; if (st_rd_first !== 1)   begin bad++; $display("FAIL nom_rd_first: got %0d want 1", st_rd_first); end
        total++; if (st_rd_runs !== 1)    begin bad++; $display("FAIL nom_rd_runs: got %0d want 1", st_rd_runs); end
        total++; if (st_wr !== NWIN)      begin bad++; $display("FAIL nom_wr_count: got %0d want %0d", st_wr, NWIN); end
        total++; if (st_wr_first !== 1 + RD2WR) begin bad++; $display("FAIL nom_wr_first: got %0d want %0d", st_wr_first, 1 + RD2WR); end
        total++; if (st_wr_runs !== 1)    begin bad++; $display("FAIL nom_wr_runs: got %0d want 1", st_wr_runs); end
        total++; if (st_done_n !== 1)     begin bad++; $display("FAIL nom_done_n: got %0d want 1", st_done_n); end
        total++; if (st_done_e !== NWIN + RD2WR + 1) begin bad++; $display("FAIL nom_done_edge: got %0d want %0d", st_done_e, NWIN + RD2WR + 1); end
        total++; if (st_busy_fall_e !== NWIN + RD2WR + 1) begin bad++; $display("FAIL nom_busy_fall: got %0d want %0d", st_busy_fall_e, NWIN + RD2WR + 1); end
        total++; if (st_coord_256 !== {5'd0, 8'd255}) begin bad++; $display("FAIL nom_coord_0_255: got %h want %h", st_coord_256, {5'd0, 8'd255}); end
        total++; if (st_coord_257 !== {5'd1, 8'd0}) begin bad++; $display("FAIL nom_wrap: got %h want %h", st_coord_257, {5'd1, 8'd0}); end
        total++; if (st_last_coord !== {5'd31, 8'd255}) begin bad++; $display("FAIL nom_last: got %h want %h", st_last_coord, {5'd31, 8'd255}); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL nom_stall_cnt: got %0d want 0", stall_cnt); end
        $display("test_nominal: rd=%0d wr=%0d done_edge=%0d", st_rd, st_wr, st_done_e);
    endtask

    task automatic test_stall;
        int h = 3 * COLS + 11;
        run_frame(NWIN + 100, h, 5, -1, -1, 0);
        total++; if (st_rd !== NWIN)      begin bad++; $display("FAIL stall_rd_count: got %0d want %0d", st_rd, NWIN); end
        total++; if (st_rd_runs !== 2)    begin bad++; $display("FAIL stall_rd_runs: got %0d want 2", st_rd_runs); end
        total++; if (st_rd_last !== NWIN + 5) begin bad++; $display("FAIL stall_rd_last: got %0d want %0d", st_rd_last, NWIN + 5); end
        total++; if (st_frozen_bad !== 0) begin bad++; $display("FAIL stall_col_frozen: got %0d moves want 0", st_frozen_bad); end
        total++; if (st_wr !== NWIN)      begin bad++; $display("FAIL stall_wr_count: got %0d want %0d", st_wr, NWIN); end
        total++; if (st_wr_runs !== 2)    begin bad++; $display("FAIL stall_wr_runs: got %0d want 2", st_wr_runs); end
        total++; if (st_wr_last !== NWIN + 5 + RD2WR) begin bad++; $display("FAIL stall_wr_last: got %0d want %0d", st_wr_last, NWIN + 5 + RD2WR); end
        total++; if (st_done_e !== NWIN + RD2WR + 6) begin bad++; $display("FAIL stall_done_edge: got %0d want %0d", st_done_e, NWIN + RD2WR + 6); end
        total++; if (stall_cnt !== 16'(EXP_STALL)) begin bad++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, EXP_STALL); end
        $display("test_stall: rd=%0d wr=%0d done_edge=%0d stall_cnt=%0d", st_rd, st_wr, st_done_e, stall_cnt);
    endtask

    task automatic test_ignored_start;
        run_frame(NWIN + 100, -10, 0, 2000, -1, 0);
        total++; if (st_rd !== NWIN)   begin bad++; $display("FAIL ign_mid_rd_count: got %0d want %0d", st_rd, NWIN); end
        total++; if (st_done_n !== 1)  begin bad++; $display("FAIL ign_mid_done_n: got %0d want 1", st_done_n); end
        total++; if (st_done_e !== NWIN + RD2WR + 1) begin bad++; $display("FAIL ign_mid_done_edge: got %0d want %0d", st_done_e, NWIN + RD2WR + 1); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL ign_stall_clear: got %0d want 0", stall_cnt); end
        // Second pass pulses start on the edge taken while in DONE.
        run_frame(NWIN + 100, -10, 0, NWIN + RD2WR + 2, -1, 0);
        total++; if (st_done_n !== 1)  begin bad++; $display("FAIL ign_done_done_n: got %0d want 1", st_done_n); end
        total++; if (st_busy_after_done !== 0) begin bad++; $display("FAIL ign_done_busy: got %0d busy cycles want 0", st_busy_after_done); end
        total++; if (st_rd_after_done !== 0) begin bad++; $display("FAIL ign_done_rd: got %0d rd cycles want 0", st_rd_after_done); end
        $display("test_ignored_start: done_n=%0d done_edge=%0d", st_done_n, st_done_e);
    endtask

    task automatic test_midframe_reset;
        run_frame(1006, -10, 0, -1, 1001, 3);
        total++; if (st_rd !== 1000)    begin bad++; $display("FAIL mrst_rd_before: got %0d want 1000", st_rd); end
        total++; if (st_wr_in_rst !== 0) begin bad++; $display("FAIL mrst_wr_in_reset: got %0d want 0", st_wr_in_rst); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
        total++; if (row !== '0 || col !== '0) begin bad++; $display("FAIL mrst_coord: got (%0d,%0d) want (0,0)", row, col); end
        run_frame(NWIN + 100, -10, 0, -1, -1, 0);
        total++; if (st_wr_first !== 1 + RD2WR) begin bad++; $display("FAIL mrst_wr_first: got %0d want %0d", st_wr_first, 1 + RD2WR); end
        total++; if (st_coord_257 !== {5'd1, 8'd0}) begin bad++; $display("FAIL mrst_wrap: got %h want %h", st_coord_257, {5'd1, 8'd0}); end
        total++; if (st_wr !== NWIN)    begin bad++; $display("FAIL mrst_wr_count: got %0d want %0d", st_wr, NWIN); end
        total++; if (st_done_e !== NWIN + RD2WR + 1) begin bad++; $display("FAIL mrst_done_edge: got %0d want %0d", st_done_e, NWIN + RD2WR + 1); end
        $display("test_midframe_reset: wr=%0d done_edge=%0d", st_wr, st_done_e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        hold  = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_stall();
        test_ignored_start();
        test_midframe_reset();
        total++;
        if (rd_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending rd want 0", rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
